multi_sine_reader: RTL

- Parametrised, multi-channel successor to the single-voice sine reader.
- NUM_CH independent phase accumulators time-share one quarter-wave sine ROM, round-robin, once per sample tick.
- Sits between the note/step generator and the codec/mixer path. Emits one tagged sample per channel per tick, plus a frame-done strobe.

---
 rtl/multi_sine_pkg.sv | 29 ++
 rtl/sine_rom_q.sv | 26 ++
 rtl/multi_sine_reader.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/multi_sine_pkg.sv
// rtl/multi_sine_pkg.sv - shared types, default widths and helpers for multi_sine_reader
package multi_sine_pkg;

  localparam int DEF_NUM_CH   = 3;
  localparam int DEF_ADDR_W   = 10;
  localparam int DEF_FRAC_W   = 10;
  localparam int DEF_STEP_W   = 20;
  localparam int DEF_SAMPLE_W = 16;

  typedef enum logic [1:0] {Q0 = 2'd0, Q1 = 2'd1, Q2 = 2'd2, Q3 = 2'd3} quad_e;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  function automatic logic [31:0] phase_field(input logic [63:0] phase, input int lsb,
                                              input int width);
    logic [63:0] mask;
    mask = (64'd1 << width) - 64'd1;
    return 32'((phase >> lsb) & mask);
  endfunction

  // Parabolic quarter-wave: full scale at the last address, never reaching 2^(sample_w-1).
  function automatic logic [31:0] rom_word(input int idx, input int addr_w, input int sample_w);
    longint n, d, maxv;
    n    = longint'(idx) + 1;
    d    = longint'(1) << addr_w;
    maxv = (longint'(1) << (sample_w - 1)) - 1;
    return 32'((maxv * n * (2 * d - n)) >>> (2 * addr_w));
  endfunction

endpackage

// File: rtl/sine_rom_q.sv
// rtl/sine_rom_q.sv - synchronous quarter-wave sine ROM, one cycle read latency
module sine_rom_q
  import multi_sine_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int SAMPLE_W = DEF_SAMPLE_W
) (
  input  logic                clk,
  input  logic [ADDR_W-1:0]   addr_i,
  output logic [SAMPLE_W-1:0] data_o
);

  logic [SAMPLE_W-1:0] rom_w [2**ADDR_W];
  logic [SAMPLE_W-1:0] data_q;

  for (genvar i = 0; i < 2**ADDR_W; i++) begin : g_rom
    assign rom_w[i] = SAMPLE_W'(rom_word(i, ADDR_W, SAMPLE_W));
  end

  always_ff @(posedge clk) begin
    data_q <= rom_w[addr_i];
  end

  assign data_o = data_q;

endmodule

// File: rtl/multi_sine_reader.sv
// rtl/multi_sine_reader.sv - round-robin multi-channel sine reader; MULTI_SINE_MIX_EN adds a saturated frame mix
module multi_sine_reader
  import multi_sine_pkg::*;
#(
  parameter int NUM_CH    = DEF_NUM_CH,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int FRAC_W    = DEF_FRAC_W,
  parameter int STEP_W    = DEF_STEP_W,
  parameter int SAMPLE_W  = DEF_SAMPLE_W,
  localparam int PHASE_W  = ADDR_W + 2 + FRAC_W,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       generate_next,
  input  logic [NUM_CH*STEP_W-1:0]   step_size,
  input  logic [NUM_CH-1:0]          ch_en,
  input  logic [NUM_CH-1:0]          phase_clr,
  output logic                       sample_valid,
  output logic signed [SAMPLE_W-1:0] sample,
  output logic [CH_W-1:0]            sample_ch,
  output logic                       frame_done,
`ifdef MULTI_SINE_MIX_EN
  output logic signed [SAMPLE_W-1:0] mix_sample,
  output logic                       mix_valid,
`endif
  output logic                       overrun
);

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  state_e              state_q, state_d;
  logic [CH_W-1:0]     idx_q, idx_d;
  logic                overrun_q, overrun_d;
  logic [PHASE_W-1:0]  phase_q [NUM_CH];
  logic [PHASE_W-1:0]  phase_d [NUM_CH];
  logic                issue;
  logic [PHASE_W-1:0]  cur_phase;
  logic                cur_en;
  quad_e               cur_quad;
  logic [ADDR_W-1:0]   raw_addr, rom_addr;
  logic [SAMPLE_W-1:0] rom_data;

  logic                s1_valid_q, s1_en_q, s1_neg_q, s1_last_q;
  logic [CH_W-1:0]     s1_ch_q;

  logic signed [SAMPLE_W-1:0] rom_s, sample_d, sample_q;
  logic                       sample_valid_q, frame_done_q;
  logic [CH_W-1:0]            sample_ch_q;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    overrun_d = overrun_q;
    unique case (state_q)
      IDLE: begin
        if (generate_next) begin
          state_d = RUN;
          idx_d   = '0;
        end
      end
      RUN: begin
        if (generate_next) overrun_d = 1'b1;
        if (idx_q == LAST_CH) state_d = IDLE;
        else                  idx_d   = idx_q + CH_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  assign issue = (state_q == RUN);

  // A clear wins over the increment, but the issued address still uses the old phase.
  always_comb begin
    cur_phase = '0;
    cur_en    = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (idx_q == CH_W'(k)) begin
        cur_phase = phase_q[k];
        cur_en    = ch_en[k];
      end
      phase_d[k] = phase_q[k];
      if (issue && (idx_q == CH_W'(k)) && ch_en[k])
        phase_d[k] = phase_q[k] + PHASE_W'(step_size[k*STEP_W +: STEP_W]);
      if (phase_clr[k]) phase_d[k] = '0;
    end
  end

  assign cur_quad = quad_e'(2'(phase_field(64'(cur_phase), PHASE_W - 2, 2)));
  assign raw_addr = ADDR_W'(phase_field(64'(cur_phase), FRAC_W, ADDR_W));
  assign rom_addr = ((cur_quad == Q1) || (cur_quad == Q3)) ? ~raw_addr : raw_addr;

  sine_rom_q #(
    .ADDR_W   (ADDR_W),
    .SAMPLE_W (SAMPLE_W)
  ) u_rom (
    .clk    (clk),
    .addr_i (rom_addr),
    .data_o (rom_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      overrun_q  <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_en_q    <= 1'b0;
      s1_neg_q   <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_ch_q    <= '0;
      for (int k = 0; k < NUM_CH; k++) phase_q[k] <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      overrun_q  <= overrun_d;
      s1_valid_q <= issue;
      s1_en_q    <= cur_en;
      s1_neg_q   <= (cur_quad == Q2) || (cur_quad == Q3);
      s1_last_q  <= (idx_q == LAST_CH);
      s1_ch_q    <= idx_q;
      for (int k = 0; k < NUM_CH; k++) phase_q[k] <= phase_d[k];
    end
  end

  assign rom_s    = signed'(rom_data);
  assign sample_d = !s1_en_q ? '0 : (s1_neg_q ? -rom_s : rom_s);

  always_ff @(posedge clk) begin
    if (reset) begin
      sample_valid_q <= 1'b0;
      frame_done_q   <= 1'b0;
      sample_q       <= '0;
      sample_ch_q    <= '0;
    end else begin
      sample_valid_q <= s1_valid_q;
      frame_done_q   <= s1_valid_q && s1_last_q;
      if (s1_valid_q) begin
        sample_q    <= sample_d;
        sample_ch_q <= s1_ch_q;
      end
    end
  end

  assign sample_valid = sample_valid_q;
  assign sample       = sample_q;
  assign sample_ch    = sample_ch_q;
  assign frame_done   = frame_done_q;
  assign overrun      = overrun_q;

`ifdef MULTI_SINE_MIX_EN
  localparam int ACC_W = SAMPLE_W + CH_W + 1;
  localparam logic signed [ACC_W-1:0] SAT_HI = {{(CH_W + 2){1'b0}}, {(SAMPLE_W - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_LO = {{(CH_W + 2){1'b1}}, {(SAMPLE_W - 1){1'b0}}};

  logic signed [ACC_W-1:0]    acc_q, acc_base, sample_ext;
  logic signed [SAMPLE_W-1:0] mix_d, mix_sample_q;
  logic                       mix_valid_q;

  // Channel 0 restarts the sum, so a back-to-back tick never clears a frame still finishing.
  assign acc_base   = (s1_ch_q == '0) ? '0 : acc_q;
  assign sample_ext = {{(ACC_W - SAMPLE_W){sample_d[SAMPLE_W-1]}}, sample_d};

  always_comb begin
    mix_d = acc_q[SAMPLE_W-1:0];
    if (acc_q > SAT_HI)      mix_d = {1'b0, {(SAMPLE_W - 1){1'b1}}};
    else if (acc_q < SAT_LO) mix_d = {1'b1, {(SAMPLE_W - 1){1'b0}}};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q        <= '0;
      mix_valid_q  <= 1'b0;
      mix_sample_q <= '0;
    end else begin
      if (s1_valid_q) acc_q <= acc_base + sample_ext;
      mix_valid_q <= frame_done_q;
      if (frame_done_q) mix_sample_q <= mix_d;
    end
  end

  assign mix_sample = mix_sample_q;
  assign mix_valid  = mix_valid_q;
`else
  // Without mixing the output register is the end of the datapath.
`endif

endmodule
